// File: rtl/bsg_tag_client_unpacker.sv
//------------------------------------------------------------------------------
// Module  : bsg_tag_client_unpacker
// Brief   : Tag client endpoint; assembles LSB-first payload bits into words
//           presented on a valid/yumi interface, with tag reset and overrun.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_tag_client_unpacker #(
    parameter int                 width_p   = 16,
    parameter logic [width_p-1:0] default_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               op_i,
    input  logic               param_i,
    output logic [width_p-1:0] data_o,
    output logic               data_v_o,
    input  logic               data_yumi_i,
    output logic               tag_reset_o,
    output logic               overrun_o
);

    localparam int CNT_W = $clog2(width_p + 1);

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [width_p-1:0] sr_q,    sr_d;
    logic [width_p-1:0] data_q,  data_d;
    logic               v_q,     v_d;
    logic               trst_q,  trst_d;
    logic               ovr_q,   ovr_d;

    logic               w_shift;
    logic               w_tagrst;
    logic               w_last;
    logic               w_complete;
    logic [width_p-1:0] w_sr_shift;

    assign w_shift    = en_i &  op_i;
    assign w_tagrst   = en_i & ~op_i & param_i;
    assign w_last     = (cnt_q == CNT_W'(width_p - 1));
    assign w_complete = w_shift & w_last;

    // New bits enter at the top so the first bit ends up in bit 0.
    if (width_p == 1) begin : g_w1
        assign w_sr_shift = param_i;
    end else begin : g_wn
        assign w_sr_shift = {param_i, sr_q[width_p-1:1]};
    end

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        data_d = data_q;
        v_d    = v_q;
        trst_d = trst_q;
        ovr_d  = ovr_q;

        if (w_tagrst) begin
            sr_d   = '0;
            cnt_d  = '0;
            trst_d = 1'b1;
        end else if (w_shift) begin
            trst_d = 1'b0;
            sr_d   = w_sr_shift;
            cnt_d  = w_last ? '0 : cnt_q + CNT_W'(1);
        end

        // Latest word wins; an unconsumed word being replaced is an overrun.
        if (w_complete) begin
            data_d = w_sr_shift;
            v_d    = 1'b1;
            if (v_q && !data_yumi_i) begin
                ovr_d = 1'b1;
            end
        end else if (data_yumi_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            data_q <= default_p;
            v_q    <= 1'b0;
            trst_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            data_q <= data_d;
            v_q    <= v_d;
            trst_q <= trst_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign data_v_o    = v_q;
    assign tag_reset_o = trst_q;
    assign overrun_o   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_tag_client_unpacker.sv
//------------------------------------------------------------------------------
// Module  : tb_bsg_tag_client_unpacker
// Brief   : Self-checking bench driving widths 16, 1 and 64 from one stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_tag_client_unpacker;

    localparam logic [15:0] DEF16 = 16'h1357;
    localparam logic [0:0]  DEF1  = 1'b1;
    localparam logic [63:0] DEF64 = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, op = 1'b0, param = 1'b0;
    logic yumi16 = 1'b0, yumi1 = 1'b0, yumi64 = 1'b0;

    logic [15:0] data16;
    logic [0:0]  data1;
    logic [63:0] data64;
    logic v16, v1, v64, tr16, tr1, tr64, ov16, ov1, ov64;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    // yumi request mode per DUT: 0 = never, 1 = whenever valid, 2 = random
    int ym16 = 0, ym1 = 2, ym64 = 2;

    always #5 clk = ~clk;

    bsg_tag_client_unpacker #(.width_p(16), .default_p(DEF16)) u16 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .op_i(op), .param_i(param),
        .data_o(data16), .data_v_o(v16), .data_yumi_i(yumi16),
        .tag_reset_o(tr16), .overrun_o(ov16));
    bsg_tag_client_unpacker #(.width_p(1), .default_p(DEF1)) u1 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .op_i(op), .param_i(param),
        .data_o(data1), .data_v_o(v1), .data_yumi_i(yumi1),
        .tag_reset_o(tr1), .overrun_o(ov1));
    bsg_tag_client_unpacker #(.width_p(64), .default_p(DEF64)) u64 (
        .clk_i(clk), .reset_i(rst), .en_i(en), .op_i(op), .param_i(param),
        .data_o(data64), .data_v_o(v64), .data_yumi_i(yumi64),
        .tag_reset_o(tr64), .overrun_o(ov64));

    // Reference model: bits collected by index, word emitted when w bits seen.
    typedef struct packed {
        logic [63:0] acc;
        logic [31:0] cnt;
        logic [63:0] data;
        logic        v;
        logic        ovr;
        logic        trst;
    } mst_t;

    mst_t m16, m1, m64;

    function automatic mst_t mreset(logic [63:0] def);
        mst_t s;
        s = '0;
        s.data = def;
        return s;
    endfunction

    function automatic mst_t step(mst_t s, int w, logic e, logic o, logic p, logic y);
        mst_t n;
        bit   done;
        n    = s;
        done = 1'b0;
        if (e && !o && p) begin
            n.acc  = '0;
            n.cnt  = 0;
            n.trst = 1'b1;
        end else if (e && o) begin
            n.trst       = 1'b0;
            n.acc[n.cnt] = p;
            n.cnt        = n.cnt + 1;
            if (int'(n.cnt) == w) begin
                done  = 1'b1;
                n.cnt = 0;
            end
        end
        if (done) begin
            n.data = n.acc;
            n.acc  = '0;
            if (s.v && !y) n.ovr = 1'b1;
            n.v = 1'b1;
        end else if (y) begin
            n.v = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16 <= mreset({48'b0, DEF16});
            m1  <= mreset({63'b0, DEF1});
            m64 <= mreset(DEF64);
        end else begin
            m16 <= step(m16, 16, en, op, param, yumi16);
            m1  <= step(m1,  1,  en, op, param, yumi1);
            m64 <= step(m64, 64, en, op, param, yumi64);
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("d16.data", {48'b0, data16}, m16.data);
            check("d16.v",    {63'b0, v16},    {63'b0, m16.v});
            check("d16.trst", {63'b0, tr16},   {63'b0, m16.trst});
            check("d16.ovr",  {63'b0, ov16},   {63'b0, m16.ovr});
            check("d1.data",  {63'b0, data1},  m1.data);
            check("d1.v",     {63'b0, v1},     {63'b0, m1.v});
            check("d1.trst",  {63'b0, tr1},    {63'b0, m1.trst});
            check("d1.ovr",   {63'b0, ov1},    {63'b0, m1.ovr});
            check("d64.data", data64,          m64.data);
            check("d64.v",    {63'b0, v64},    {63'b0, m64.v});
            check("d64.trst", {63'b0, tr64},   {63'b0, m64.trst});
            check("d64.ovr",  {63'b0, ov64},   {63'b0, m64.ovr});
            if (yumi16) check("yumi16_legal", {63'b0, v16}, 64'd1);
            if (yumi1)  check("yumi1_legal",  {63'b0, v1},  64'd1);
            if (yumi64) check("yumi64_legal", {63'b0, v64}, 64'd1);
        end
    end

    function automatic logic ysel(int mode, logic valid);
        logic r;
        case (mode)
            1:       r = 1'b1;
            2:       r = 1'($urandom_range(0, 1));
            default: r = 1'b0;
        endcase
        return r & valid;
    endfunction

    task automatic send(logic e, logic o, logic p);
        @(posedge clk);
        #2;
        en     = e;
        op     = o;
        param  = p;
        yumi16 = ysel(ym16, m16.v);
        yumi1  = ysel(ym1,  m1.v);
        yumi64 = ysel(ym64, m64.v);
    endtask

    task automatic nop();
        send(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(logic [63:0] val, int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b1, val[i]);
    endtask

    task automatic do_reset(bit chk);
        @(posedge clk);
        #2;
        en = 1'b0; op = 1'b0; param = 1'b0;
        yumi16 = 1'b0; yumi1 = 1'b0; yumi64 = 1'b0;
        #2 rst = 1'b1;
        #1;
        if (chk) begin
            check("arst.data16", {48'b0, data16}, {48'b0, DEF16});
            check("arst.v16",    {63'b0, v16},    64'd0);
            check("arst.trst16", {63'b0, tr16},   64'd0);
            check("arst.ovr16",  {63'b0, ov16},   64'd0);
            check("arst.data1",  {63'b0, data1},  {63'b0, DEF1});
            check("arst.data64", data64,          DEF64);
        end
        #3 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w16;
        logic        b;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset.data16", {48'b0, data16}, {48'b0, DEF16});
        check("reset.v16",    {63'b0, v16},    64'd0);
        check("reset.trst16", {63'b0, tr16},   64'd0);
        check("reset.ovr16",  {63'b0, ov16},   64'd0);

        // Basic word and consumption
        ym16 = 0;
        send_bits(64'hA5C3, 16);
        nop();
        @(negedge clk);
        check("basic.data", {48'b0, data16}, 64'hA5C3);
        check("basic.v",    {63'b0, v16},    64'd1);
        check("basic.ovr",  {63'b0, ov16},   64'd0);
        ym16 = 1; nop(); ym16 = 0; nop();
        @(negedge clk);
        check("yumi.v",    {63'b0, v16},    64'd0);
        check("yumi.data", {48'b0, data16}, 64'hA5C3);

        // Interleaved NOPs
        w16 = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            int k;
            k = 1 + $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 1) == 0) nop();
                else send(1'b1, 1'b0, 1'b0);
            end
            if (i == 15) begin
                @(negedge clk);
                check("nops.early_v", {63'b0, v16}, 64'd0);
            end
            send(1'b1, 1'b1, w16[i]);
        end
        nop();
        @(negedge clk);
        check("nops.data", {48'b0, data16}, 64'h1234);
        check("nops.v",    {63'b0, v16},    64'd1);

        // Overrun, then the same sequence with yumi on the second completion
        do_reset(1'b0);
        send_bits(64'h00FF, 16);
        send_bits(64'hFF00, 16);
        nop();
        @(negedge clk);
        check("ovr.data", {48'b0, data16}, 64'hFF00);
        check("ovr.v",    {63'b0, v16},    64'd1);
        check("ovr.flag", {63'b0, ov16},   64'd1);
        do_reset(1'b0);
        send_bits(64'h00FF, 16);
        send_bits(64'h7F00, 15);
        ym16 = 1; send(1'b1, 1'b1, 1'b1); ym16 = 0;
        nop();
        @(negedge clk);
        check("noovr.data", {48'b0, data16}, 64'hFF00);
        check("noovr.v",    {63'b0, v16},    64'd1);
        check("noovr.flag", {63'b0, ov16},   64'd0);

        // TAGRST mid-word
        do_reset(1'b0);
        send_bits(64'h7F, 7);
        send(1'b1, 1'b0, 1'b1);
        nop();
        @(negedge clk);
        check("trst.level", {63'b0, tr16}, 64'd1);
        nop();
        send(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("trst.held", {63'b0, tr16}, 64'd1);
        nop();
        @(negedge clk);
        check("trst.clear", {63'b0, tr16}, 64'd0);
        send_bits(64'hBEEF >> 1, 15);
        nop();
        @(negedge clk);
        check("trst.data", {48'b0, data16}, 64'hBEEF);

        // Async reset mid-word after building up non-reset state
        send_bits(64'h0001, 16);
        send(1'b1, 1'b0, 1'b1);
        send_bits(64'h3FF, 10);
        do_reset(1'b1);
        send_bits(64'h5A5A, 16);
        nop();
        @(negedge clk);
        check("arst.word", {48'b0, data16}, 64'h5A5A);

        // width 1
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            b = 1'($urandom_range(0, 1));
            send(1'b1, 1'b1, b);
            nop();
            @(negedge clk);
            check("w1.data", {63'b0, data1}, {63'b0, b});
            check("w1.v",    {63'b0, v1},    64'd1);
        end

        // width 64
        do_reset(1'b0);
        ym64 = 0;
        send_bits(64'h0123_4567_89AB_CDEF, 64);
        nop();
        @(negedge clk);
        check("w64.data", data64, 64'h0123_4567_89AB_CDEF);
        check("w64.v",    {63'b0, v64}, 64'd1);

        // Random traffic against the model
        do_reset(1'b0);
        ym16 = 2; ym1 = 2; ym64 = 2;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0)      send(1'b1, 1'b0, 1'b1);
            else if (r < 6)  nop();
            else if (r < 8)  send(1'b1, 1'b0, 1'b0);
            else             send(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        nop();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
